// File: rtl/operand_fetch.sv
// operand_fetch: register-read stage with writeback forwarding, per-register scoreboard and RAW/WAW stall.
// Define OPERAND_FETCH_STALL_COUNTER_EN to add a saturating hazard-stall counter output.
module operand_fetch #(
   parameter  int DATA_WIDTH    = 32,
   parameter  int NUM_REGISTERS = 32,
   parameter  int PAYLOAD_WIDTH = 16,
   localparam int REG_W         = $clog2(NUM_REGISTERS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [REG_W-1:0]         in_rs1,
   input  logic [REG_W-1:0]         in_rs2,
   input  logic                     in_uses_rs1,
   input  logic                     in_uses_rs2,
   input  logic [REG_W-1:0]         in_rd,
   input  logic [PAYLOAD_WIDTH-1:0] in_payload,
   output logic [REG_W-1:0]         rf_read_register_1,
   output logic [REG_W-1:0]         rf_read_register_2,
   input  logic [DATA_WIDTH-1:0]    rf_result_1,
   input  logic [DATA_WIDTH-1:0]    rf_result_2,
   input  logic [REG_W-1:0]         wb_register,
   input  logic [DATA_WIDTH-1:0]    wb_data,
   input  logic                     flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_WIDTH-1:0]    out_operand_1,
   output logic [DATA_WIDTH-1:0]    out_operand_2,
   output logic [REG_W-1:0]         out_rd,
   output logic [PAYLOAD_WIDTH-1:0] out_payload
`ifdef OPERAND_FETCH_STALL_COUNTER_EN
  ,output logic [31:0]              stall_count
`endif
);
   logic [NUM_REGISTERS-1:0] r_pending;
   logic [NUM_REGISTERS-1:0] w_pend_next;
   logic                     r_out_valid;
   logic [DATA_WIDTH-1:0]    r_op1, r_op2;
   logic [REG_W-1:0]         r_out_rd;
   logic [PAYLOAD_WIDTH-1:0] r_payload;
   logic                     w_wb_en, w_raw1, w_raw2, w_waw, w_hazard, w_accept;
   logic [DATA_WIDTH-1:0]    w_op1, w_op2;

   assign rf_read_register_1 = in_rs1;
   assign rf_read_register_2 = in_rs2;
   assign w_wb_en  = wb_register != '0;
   assign w_op1    = !in_uses_rs1 ? '0 : (w_wb_en && in_rs1 == wb_register) ? wb_data : rf_result_1;
   assign w_op2    = !in_uses_rs2 ? '0 : (w_wb_en && in_rs2 == wb_register) ? wb_data : rf_result_2;
   assign w_raw1   = in_uses_rs1 && in_rs1 != '0 && r_pending[in_rs1] && wb_register != in_rs1;
   assign w_raw2   = in_uses_rs2 && in_rs2 != '0 && r_pending[in_rs2] && wb_register != in_rs2;
   assign w_waw    = in_rd != '0 && r_pending[in_rd] && wb_register != in_rd;
   assign w_hazard = w_raw1 || w_raw2 || w_waw;
   assign in_ready = !rst && !flush && (!r_out_valid || out_ready) && !w_hazard;
   assign w_accept = in_valid && in_ready;

   // set is applied last so it wins over a same-index writeback clear
   always_comb begin
      w_pend_next = r_pending;
      if (w_wb_en) w_pend_next[wb_register] = 1'b0;
      if (flush && r_out_valid && r_out_rd != '0) w_pend_next[r_out_rd] = 1'b0;
      if (w_accept && in_rd != '0) w_pend_next[in_rd] = 1'b1;
      w_pend_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pending   <= '0;
         r_out_valid <= 1'b0;
         r_op1       <= '0;
         r_op2       <= '0;
         r_out_rd    <= '0;
         r_payload   <= '0;
      end else begin
         r_pending <= w_pend_next;
         if (flush) r_out_valid <= 1'b0;
         else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_op1       <= w_op1;
            r_op2       <= w_op2;
            r_out_rd    <= in_rd;
            r_payload   <= in_payload;
         end else if (out_ready) r_out_valid <= 1'b0;
      end
   end

   assign out_valid     = r_out_valid;
   assign out_operand_1 = r_op1;
   assign out_operand_2 = r_op2;
   assign out_rd        = r_out_rd;
   assign out_payload   = r_payload;

`ifdef OPERAND_FETCH_STALL_COUNTER_EN
   logic [31:0] r_stall;
   always_ff @(posedge clk) begin
      if (rst) r_stall <= '0;
      else if (in_valid && w_hazard && !flush && r_stall != '1) r_stall <= r_stall + 32'd1;
   end
   assign stall_count = r_stall;
`endif
endmodule
